// File: rtl/tile_iso_pkg.sv
// rtl/tile_iso_pkg.sv - shared types and default parameters for the tile isolation controller
package tile_iso_pkg;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } iso_state_e;

    localparam int unsigned DefNumPorts      = 4;
    localparam int unsigned DefMaxTxns       = 16;
    localparam int unsigned DefTimeoutCycles = 1024;

endpackage

// File: rtl/tile_iso_txn_cnt.sv
// rtl/tile_iso_txn_cnt.sv - per-port request gating, pending bit and outstanding-transaction counter
module tile_iso_txn_cnt
    import tile_iso_pkg::*;
#(
    parameter int unsigned MaxTxns  = DefMaxTxns,
    parameter int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                active_i,
    input  logic                req_valid_i,
    input  logic                req_ready_i,
    input  logic                rsp_done_i,
    output logic                req_valid_o,
    output logic                req_ready_o,
    output logic                pending_o,
    output logic [CntWidth-1:0] cnt_o,
    output logic                proto_err_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxns);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                err_q, err_d;
    logic                en;
    logic                req_hs;

    // A request already shown downstream keeps its path open until it completes.
    assign en          = (active_i && (cnt_q < CntMax)) || pending_q;
    assign req_valid_o = req_valid_i & en;
    assign req_ready_o = req_ready_i & en;
    assign req_hs      = req_valid_o & req_ready_i;
    assign pending_d   = req_valid_o & ~req_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (req_hs && !rsp_done_i) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (rsp_done_i && !req_hs) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending_o   = pending_q;
    assign cnt_o       = cnt_q;
    assign proto_err_o = err_q;

endmodule

// File: rtl/tile_isolation_ctrl.sv
// rtl/tile_isolation_ctrl.sv - isolation FSM, drain watchdog and per-port transaction trackers
module tile_isolation_ctrl
    import tile_iso_pkg::*;
#(
    parameter  int unsigned NumPorts      = DefNumPorts,
    parameter  int unsigned MaxTxns       = DefMaxTxns,
    parameter  int unsigned TimeoutCycles = DefTimeoutCycles,
    localparam int unsigned CntWidth      = $clog2(MaxTxns + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         isolate_i,
    output logic                         isolated_o,
    output logic                         drain_timeout_o,
    output logic [NumPorts-1:0]          protocol_err_o,
    input  logic [NumPorts-1:0]          slv_req_valid_i,
    output logic [NumPorts-1:0]          slv_req_ready_o,
    output logic [NumPorts-1:0]          mst_req_valid_o,
    input  logic [NumPorts-1:0]          mst_req_ready_i,
    input  logic [NumPorts-1:0]          rsp_valid_i,
    input  logic [NumPorts-1:0]          rsp_ready_i,
    input  logic [NumPorts-1:0]          rsp_last_i,
    output logic [NumPorts*CntWidth-1:0] outstanding_o
);

    iso_state_e          state_q, state_d;
    logic [NumPorts-1:0] rsp_done;
    logic [NumPorts-1:0] pending;
    logic [NumPorts-1:0] cnt_zero;
    logic                all_idle;

    assign rsp_done = rsp_valid_i & rsp_ready_i & rsp_last_i;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        logic [CntWidth-1:0] cnt;

        tile_iso_txn_cnt #(
            .MaxTxns (MaxTxns),
            .CntWidth(CntWidth)
        ) u_txn_cnt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .active_i   (state_q == ACTIVE),
            .req_valid_i(slv_req_valid_i[p]),
            .req_ready_i(mst_req_ready_i[p]),
            .rsp_done_i (rsp_done[p]),
            .req_valid_o(mst_req_valid_o[p]),
            .req_ready_o(slv_req_ready_o[p]),
            .pending_o  (pending[p]),
            .cnt_o      (cnt),
            .proto_err_o(protocol_err_o[p])
        );

        assign cnt_zero[p]                           = (cnt == '0);
        assign outstanding_o[p*CntWidth +: CntWidth] = cnt;
    end

    assign all_idle = (&cnt_zero) && !(|pending);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE:   if (isolate_i) state_d = DRAIN;
            DRAIN: begin
                if (!isolate_i)    state_d = ACTIVE;
                else if (all_idle) state_d = ISOLATED;
            end
            ISOLATED: if (!isolate_i) state_d = ACTIVE;
            default:  state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    assign isolated_o = (state_q == ISOLATED);

    if (TimeoutCycles > 0) begin : g_wd
        localparam int unsigned    WdWidth = $clog2(TimeoutCycles + 1);
        localparam logic [WdWidth-1:0] WdMax = WdWidth'(TimeoutCycles);

        logic [WdWidth-1:0] wd_q, wd_d;
        logic               to_q, to_d;

        // Counter saturates at the limit; the flag stays up until the tile is released.
        always_comb begin
            wd_d = wd_q;
            to_d = to_q;
            if (state_q == DRAIN) begin
                if (wd_q != WdMax) wd_d = wd_q + WdWidth'(1);
                if (wd_d == WdMax) to_d = 1'b1;
            end else begin
                wd_d = '0;
            end
            if (state_d == ACTIVE) begin
                wd_d = '0;
                to_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wd_q <= '0;
                to_q <= 1'b0;
            end else begin
                wd_q <= wd_d;
                to_q <= to_d;
            end
        end

        assign drain_timeout_o = to_q;
    end else begin : g_no_wd
        assign drain_timeout_o = 1'b0;
    end

endmodule

// File: tb/tb_tile_isolation_ctrl.sv
// tb/tb_tile_isolation_ctrl.sv - self-checking bench with a cycle-level behavioural model
module tb_tile_isolation_ctrl;

    localparam int NP = 4;
    localparam int MT = 16;
    localparam int TO = 8;
    localparam int CW = 5;
    localparam int S_ACT = 0, S_DRN = 1, S_ISO = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            iso = 1'b0;
    logic [NP-1:0]   sv = '0, mr = '0, rv = '0, rr = '0, rl = '0;
    logic            isolated, dto;
    logic [NP-1:0]   perr, sready, mvalid;
    logic [NP*CW-1:0] outst;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    tile_isolation_ctrl #(
        .NumPorts     (NP),
        .MaxTxns      (MT),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .isolate_i      (iso),
        .isolated_o     (isolated),
        .drain_timeout_o(dto),
        .protocol_err_o (perr),
        .slv_req_valid_i(sv),
        .slv_req_ready_o(sready),
        .mst_req_valid_o(mvalid),
        .mst_req_ready_i(mr),
        .rsp_valid_i    (rv),
        .rsp_ready_i    (rr),
        .rsp_last_i     (rl),
        .outstanding_o  (outst)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Model: outstanding counts, open presentations, mode and time spent draining.
    int m_cnt[NP];
    bit m_pend[NP];
    bit m_err[NP];
    int m_state;
    int m_dcyc;
    bit m_to;

    function automatic bit exp_en(input int p);
        return (m_state == S_ACT && m_cnt[p] < MT) || m_pend[p];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                m_cnt[p]  <= 0;
                m_pend[p] <= 1'b0;
                m_err[p]  <= 1'b0;
            end
            m_state <= S_ACT;
            m_dcyc  <= 0;
            m_to    <= 1'b0;
        end else begin
            bit idle;
            int nxt;
            idle = 1'b1;
            for (int p = 0; p < NP; p++) begin
                bit mv, hs, done;
                int delta;
                if (m_cnt[p] != 0 || m_pend[p]) idle = 1'b0;
                mv    = sv[p] && exp_en(p);
                hs    = mv && mr[p];
                done  = rv[p] && rr[p] && rl[p];
                delta = int'(hs) - int'(done);
                if (m_cnt[p] + delta < 0) m_err[p] <= 1'b1;
                else                      m_cnt[p] <= m_cnt[p] + delta;
                m_pend[p] <= mv && !mr[p];
            end
            nxt = m_state;
            if (m_state == S_ACT && iso) nxt = S_DRN;
            else if (m_state == S_DRN && !iso) nxt = S_ACT;
            else if (m_state == S_DRN && idle) nxt = S_ISO;
            else if (m_state == S_ISO && !iso) nxt = S_ACT;
            m_state <= nxt;
            if (nxt == S_ACT) begin
                m_dcyc <= 0;
                m_to   <= 1'b0;
            end else if (m_state == S_DRN) begin
                m_dcyc <= m_dcyc + 1;
                if (TO > 0 && m_dcyc + 1 >= TO) m_to <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            logic [NP-1:0]    ev, er, ee;
            logic [NP*CW-1:0] eo;
            for (int p = 0; p < NP; p++) begin
                ev[p] = sv[p] & exp_en(p);
                er[p] = mr[p] & exp_en(p);
                ee[p] = m_err[p];
                eo[p*CW +: CW] = CW'(m_cnt[p]);
            end
            chk("mst_req_valid", 32'(mvalid), 32'(ev));
            chk("slv_req_ready", 32'(sready), 32'(er));
            chk("isolated", 32'(isolated), 32'(m_state == S_ISO));
            chk("drain_timeout", 32'(dto), 32'(m_to));
            chk("protocol_err", 32'(perr), 32'(ee));
            chk("outstanding", 32'(outst), 32'(eo));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rsp(input int p);
        rv[p] = 1'b1; rr[p] = 1'b1; rl[p] = 1'b1;
        step(1);
        rv[p] = 1'b0; rr[p] = 1'b0; rl[p] = 1'b0;
    endtask

    initial begin
        step(2);
        chk("reset_isolated", 32'(isolated), 32'd0);
        chk("reset_outstanding", 32'(outst), 32'd0);
        chk("reset_perr", 32'(perr), 32'd0);
        chk("reset_timeout", 32'(dto), 32'd0);
        rst_n  = 1'b1;
        mr     = '1;
        cmp_en = 1'b1;

        // Port0: three accepted, isolate, drained by three spread responses.
        sv[0] = 1'b1; step(3); sv[0] = 1'b0;
        chk("p0_cnt3", 32'(outst[0 +: CW]), 32'd3);
        iso = 1'b1; step(1);
        sv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 1 || i == 4 || i == 8) rsp(0);
            else step(1);
            if (i == 8) chk("p0_not_yet_iso", 32'(isolated), 32'd0);
        end
        chk("p0_isolated", 32'(isolated), 32'd1);
        chk("p0_stalled", 32'(sready[0]), 32'd0);
        sv[0] = 1'b0; iso = 1'b0; step(1);

        // Idle tile: isolated two cycles after isolate rises.
        iso = 1'b1; step(1);
        chk("idle_iso_1cyc", 32'(isolated), 32'd0);
        step(1);
        chk("idle_iso_2cyc", 32'(isolated), 32'd1);
        iso = 1'b0; step(1);
        chk("idle_release", 32'(isolated), 32'd0);

        // Port1: presented request survives isolate until accepted.
        mr[1] = 1'b0; sv[1] = 1'b1; step(1);
        iso = 1'b1; step(3);
        chk("p1_valid_held", 32'(mvalid[1]), 32'd1);
        mr[1] = 1'b1; step(1); sv[1] = 1'b0;
        chk("p1_cnt1", 32'(outst[CW +: CW]), 32'd1);
        rsp(1); step(1);
        chk("p1_isolated", 32'(isolated), 32'd1);
        iso = 1'b0; step(1);

        // Port2: fill to the limit, stall, and simultaneous request/response.
        sv[2] = 1'b1; step(16);
        chk("p2_cnt16", 32'(outst[2*CW +: CW]), 32'd16);
        chk("p2_stall", 32'(sready[2]), 32'd0);
        step(2);
        rsp(2);
        chk("p2_cnt15", 32'(outst[2*CW +: CW]), 32'd15);
        step(1);
        chk("p2_refill16", 32'(outst[2*CW +: CW]), 32'd16);
        sv[2] = 1'b0; rsp(2);
        sv[2] = 1'b1; rsp(2); sv[2] = 1'b0;
        chk("p2_simul_hold", 32'(outst[2*CW +: CW]), 32'd15);
        rv[2] = 1'b1; rr[2] = 1'b1; rl[2] = 1'b1;
        step(15);
        rv[2] = 1'b0; rr[2] = 1'b0; rl[2] = 1'b0;
        chk("p2_drained", 32'(outst[2*CW +: CW]), 32'd0);

        // Port3: unanswered transaction trips the watchdog.
        sv[3] = 1'b1; step(1); sv[3] = 1'b0;
        iso = 1'b1; step(1);
        step(7);
        chk("wd_before", 32'(dto), 32'd0);
        step(1);
        chk("wd_fired", 32'(dto), 32'd1);
        step(3);
        chk("wd_sticky", 32'(dto), 32'd1);
        iso = 1'b0; step(1);
        chk("wd_cleared", 32'(dto), 32'd0);
        rsp(3);

        // Port2: response with nothing outstanding.
        rsp(2);
        chk("perr_set", 32'(perr), 32'h4);
        chk("perr_cnt0", 32'(outst[2*CW +: CW]), 32'd0);
        rst_n = 1'b0; #2;
        chk("perr_reset", 32'(perr), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a drain.
        step(1);
        sv[0] = 1'b1; step(5); sv[0] = 1'b0;
        iso = 1'b1; step(2);
        #2; rst_n = 1'b0; #1;
        chk("mid_rst_isolated", 32'(isolated), 32'd0);
        chk("mid_rst_outst", 32'(outst), 32'd0);
        iso = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; sv[0] = 1'b1; #1;
        chk("post_rst_valid", 32'(mvalid[0]), 32'd1);
        chk("post_rst_ready", 32'(sready[0]), 32'd1);
        step(1); sv[0] = 1'b0; step(2);
        chk("post_rst_cnt1", 32'(outst[0 +: CW]), 32'd1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
